// File: rtl/mem_responder_pkg.sv
// Shared word width, address width and FSM state encodings for the memory responder.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package mem_responder_pkg;

    localparam int WORD_W = `WORD_SIZE;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // An address is in range when every bit above the index field is zero.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int depth_log2);
        return (addr >> depth_log2) == '0;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word storage: one synchronous write port and two asynchronous read ports, no reset.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_W     = WORD_W
) (
    input  logic                  Clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr1,
    output logic [DATA_W-1:0]     rdata1,
    input  logic [DEPTH_LOG2-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata2
);

    logic [DATA_W-1:0] mem [1 << DEPTH_LOG2];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/mem_responder.sv
// Dual-port CPU memory model: zero-fills itself, accepts a streamed boot image, then serves fetch/data ports.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              readM1,
    input  logic [ADDR_W-1:0] address1,
    output logic [WORD_W-1:0] data1,
    input  logic              readM2,
    input  logic              writeM2,
    input  logic [ADDR_W-1:0] address2,
    inout  wire  [WORD_W-1:0] data2,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              mem_ready,
    output logic [15:0]       read_count,
    output logic [15:0]       write_count,
    output logic              error
);

    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

    state_e                state_q;
    logic [DEPTH_LOG2-1:0] idx_q;

    logic                  run;
    logic                  in1;
    logic                  in2;
    logic                  rd1_ok;
    logic                  rd2_ok;
    logic                  wr2_ok;
    logic                  violation;
    logic                  we;
    logic [DEPTH_LOG2-1:0] waddr;
    logic [WORD_W-1:0]     wdata;
    logic [WORD_W-1:0]     rdata1;
    logic [WORD_W-1:0]     rdata2;

    assign run    = (state_q == ST_RUN);
    assign in1    = in_range(address1, DEPTH_LOG2);
    assign in2    = in_range(address2, DEPTH_LOG2);
    assign rd1_ok = run & readM1 & in1;
    assign rd2_ok = run & readM2 & ~writeM2 & in2;
    assign wr2_ok = run & writeM2 & ~readM2 & in2;

    // Outside RUN every CPU request is illegal; inside RUN only conflicts and bad addresses are.
    assign violation = run ? ((readM2 & writeM2) | (readM1 & ~in1) | ((readM2 | writeM2) & ~in2))
                           : (readM1 | readM2 | writeM2);

    assign data1 = rd1_ok ? rdata1 : '0;
    assign data2 = rd2_ok ? rdata2 : 'z;

    // The single write port is shared by the zero-fill, the boot loader and the data port.
    always_comb begin
        we    = 1'b0;
        waddr = idx_q;
        wdata = '0;
        case (state_q)
            ST_CLEAR: we = 1'b1;
            ST_LOAD: begin
                we    = load_valid;
                wdata = load_data;
            end
            ST_RUN: begin
                we    = wr2_ok;
                waddr = address2[DEPTH_LOG2-1:0];
                wdata = data2;
            end
            default: we = 1'b0;
        endcase
    end

    mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (WORD_W)
    ) u_mem_array (
        .Clk    (Clk),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (address1[DEPTH_LOG2-1:0]),
        .rdata1 (rdata1),
        .raddr2 (address2[DEPTH_LOG2-1:0]),
        .rdata2 (rdata2)
    );

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q     <= ST_CLEAR;
            idx_q       <= '0;
            load_ready  <= 1'b0;
            mem_ready   <= 1'b0;
            read_count  <= '0;
            write_count <= '0;
            error       <= 1'b0;
        end else begin
            if (violation) begin
                error <= 1'b1;
            end
            if (rd2_ok && read_count != 16'hFFFF) begin
                read_count <= read_count + 16'd1;
            end
            if (wr2_ok && write_count != 16'hFFFF) begin
                write_count <= write_count + 16'd1;
            end
            case (state_q)
                // idx_q wraps to zero on the last clear, so the load pointer starts at 0.
                ST_CLEAR: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q    <= ST_LOAD;
                        load_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        idx_q <= idx_q + 1'b1;
                        if (load_last || idx_q == LAST_IDX) begin
                            state_q    <= ST_RUN;
                            load_ready <= 1'b0;
                            mem_ready  <= 1'b1;
                        end
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed-plus-random bench for mem_responder at 16 words, checked against an array model.
module tb_mem_responder;

    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b1;
    logic        readM1 = 1'b0;
    logic [15:0] address1 = '0;
    logic        readM2 = 1'b0;
    logic        writeM2 = 1'b0;
    logic [15:0] address2 = '0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        drv_en = 1'b0;
    logic [15:0] drv_val = '0;

    wire  [15:0] data1;
    tri1  [15:0] data2;
    wire         load_ready;
    wire         mem_ready;
    wire  [15:0] read_count;
    wire  [15:0] write_count;
    wire         error;

    assign data2 = drv_en ? drv_val : 'z;

    mem_responder #(.DEPTH_LOG2(DL)) dut (
        .Clk         (Clk),
        .Reset_N     (Reset_N),
        .readM1      (readM1),
        .address1    (address1),
        .data1       (data1),
        .readM2      (readM2),
        .writeM2     (writeM2),
        .address2    (address2),
        .data2       (data2),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .mem_ready   (mem_ready),
        .read_count  (read_count),
        .write_count (write_count),
        .error       (error)
    );

    always #5 Clk = ~Clk;

    logic [15:0] ref_mem [DEPTH];
    int          ref_ptr;
    int          ref_rd;
    int          ref_wr;
    logic        ref_err;
    int          n_pass;
    int          n_total;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic next();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
        ref_ptr = 0;
        ref_rd  = 0;
        ref_wr  = 0;
        ref_err = 1'b0;
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        do begin
            next();
            n++;
        end while (!load_ready && n < 40);
        chk(tag, 16'(n), 16'd16);
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        next();
        ref_mem[ref_ptr] = d;
        ref_ptr++;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic run_cycle(input string tag, input logic r1, input logic [15:0] a1,
                             input logic r2, input logic w2, input logic [15:0] a2,
                             input logic [15:0] wd);
        logic [15:0] e1;
        logic [15:0] e2;
        readM1   = r1;
        address1 = a1;
        readM2   = r2;
        writeM2  = w2;
        address2 = a2;
        drv_en   = w2 && !r2;
        drv_val  = wd;
        #1;
        e1 = (r1 && a1 < DEPTH) ? ref_mem[a1[3:0]] : 16'h0000;
        chk({tag, "_data1"}, data1, e1);
        if (!(w2 && !r2)) begin
            e2 = (r2 && !w2 && a2 < DEPTH) ? ref_mem[a2[3:0]] : 16'hFFFF;
            chk({tag, "_data2"}, data2, e2);
        end
        if (w2 && !r2 && a2 < DEPTH) begin
            ref_mem[a2[3:0]] = wd;
            ref_wr++;
        end
        if (r2 && !w2 && a2 < DEPTH) ref_rd++;
        if ((r2 && w2) || (r1 && a1 >= DEPTH) || ((r2 || w2) && a2 >= DEPTH)) ref_err = 1'b1;
        next();
        readM1  = 1'b0;
        readM2  = 1'b0;
        writeM2 = 1'b0;
        drv_en  = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        model_reset();

        #1 Reset_N = 1'b0;
        #12;
        chk("rst_load_ready", 16'(load_ready), 16'd0);
        chk("rst_mem_ready", 16'(mem_ready), 16'd0);
        chk("rst_read_count", read_count, 16'd0);
        chk("rst_write_count", write_count, 16'd0);
        chk("rst_error", 16'(error), 16'd0);
        chk("rst_data2_z", data2, 16'hFFFF);
        next();
        Reset_N = 1'b1;

        wait_clear("clear1_cycles");
        repeat ($urandom_range(1, 5)) next();
        chk("load_idle_ready", 16'(load_ready), 16'd1);
        chk("load_idle_mem_ready", 16'(mem_ready), 16'd0);
        load_word(16'h1234, 1'b0);
        load_word(16'h5678, 1'b0);
        chk("load_mid_mem_ready", 16'(mem_ready), 16'd0);
        load_word(16'h9ABC, 1'b1);
        chk("run_mem_ready", 16'(mem_ready), 16'd1);
        chk("run_load_ready", 16'(load_ready), 16'd0);
        chk("run_error", 16'(error), 16'd0);

        for (int a = 0; a < DEPTH; a++) run_cycle("fetch1", 1'b1, 16'(a), 1'b0, 1'b0, 16'h0, 16'h0);

        run_cycle("wr_beef", 1'b1, 16'd5, 1'b0, 1'b1, 16'd5, 16'hBEEF);
        run_cycle("rd_beef", 1'b0, 16'd0, 1'b1, 1'b0, 16'd5, 16'h0);
        chk("beef_write_count", write_count, 16'd1);
        chk("beef_read_count", read_count, 16'd1);

        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 2);
            run_cycle("rand", 1'($urandom_range(0, 1)), 16'($urandom_range(0, DEPTH - 1)),
                      op == 1, op == 2, 16'($urandom_range(0, DEPTH - 1)), 16'($urandom));
        end
        chk("rand_read_count", read_count, 16'(ref_rd));
        chk("rand_write_count", write_count, 16'(ref_wr));
        chk("rand_error", 16'(error), 16'(ref_err));

        run_cycle("conflict", 1'b0, 16'd0, 1'b1, 1'b1, 16'd2, 16'h0);
        chk("conflict_error", 16'(error), 16'd1);
        run_cycle("conflict_keep", 1'b1, 16'd2, 1'b0, 1'b0, 16'h0, 16'h0);
        run_cycle("oor_write", 1'b0, 16'd0, 1'b0, 1'b1, 16'h0010, 16'hAAAA);
        run_cycle("oor_keep0", 1'b1, 16'd0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_cycle("oor_reads", 1'b1, 16'h0013, 1'b1, 1'b0, 16'h8000, 16'h0);
        chk("oor_write_count", write_count, 16'(ref_wr));
        chk("oor_read_count", read_count, 16'(ref_rd));
        chk("oor_error_sticky", 16'(error), 16'(ref_err));

        Reset_N = 1'b0;
        next();
        Reset_N = 1'b1;
        model_reset();
        wait_clear("clear2_cycles");
        readM1   = 1'b1;
        address1 = 16'd0;
        #1;
        chk("early_fetch_data1", data1, 16'h0000);
        next();
        readM1 = 1'b0;
        chk("early_fetch_error", 16'(error), 16'd1);
        load_word(16'h1111, 1'b0);
        load_word(16'h2222, 1'b0);
        #2 Reset_N = 1'b0;
        #1;
        chk("midload_load_ready", 16'(load_ready), 16'd0);
        chk("midload_read_count", read_count, 16'd0);
        chk("midload_write_count", write_count, 16'd0);
        chk("midload_error", 16'(error), 16'd0);
        next();
        Reset_N = 1'b1;
        model_reset();
        wait_clear("clear3_cycles");
        load_word(16'h0042, 1'b1);
        chk("single_mem_ready", 16'(mem_ready), 16'd1);
        for (int a = 0; a < DEPTH; a++) run_cycle("fetch2", 1'b1, 16'(a), 1'b0, 1'b0, 16'h0, 16'h0);

        Reset_N = 1'b0;
        next();
        Reset_N = 1'b1;
        model_reset();
        wait_clear("clear4_cycles");
        for (int i = 0; i < DEPTH - 1; i++) load_word(16'($urandom), 1'b0);
        chk("full_mid_mem_ready", 16'(mem_ready), 16'd0);
        chk("full_mid_load_ready", 16'(load_ready), 16'd1);
        load_word(16'($urandom), 1'b0);
        chk("full_mem_ready", 16'(mem_ready), 16'd1);
        chk("full_load_ready", 16'(load_ready), 16'd0);
        for (int a = 0; a < DEPTH; a++)
            run_cycle("full_rd", 1'b1, 16'($urandom_range(0, DEPTH - 1)), 1'b1, 1'b0, 16'(a), 16'h0);
        chk("full_read_count", read_count, 16'd16);
        chk("full_error", 16'(error), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
